// File: rtl/mapper_pkg.sv
// Shared constants and types for the MegaMapper Z80 bus front-end.
package mapper_pkg;

    localparam int unsigned OFS_ISR   = 0;
    localparam int unsigned OFS_STAT  = 1;
    localparam int unsigned OFS_TRAP  = 2;
    localparam int unsigned OFS_TADDR = 3;
    localparam int unsigned OFS_CTRL  = 4;

    typedef enum logic [2:0] {
        PFX_NONE = 3'd0,
        PFX_CB   = 3'd1,
        PFX_ED   = 3'd2,
        PFX_DD   = 3'd3,
        PFX_FD   = 3'd4,
        PFX_IXCB = 3'd5
    } prefix_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CB,
        ST_ED,
        ST_IX
    } pfx_state_e;

    typedef struct packed {
        logic rd_n;
        logic wr_n;
        logic iorq_n;
        logic mreq_n;
        logic m1_n;
        logic refresh_n;
    } strobes_t;

endpackage

// File: rtl/mapper_bus_sync.sv
// Two-stage synchroniser for the Z80 bus plus a third stage for rising-edge detection.
module bus_sync
    import mapper_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    input  strobes_t   strb,
    output logic [7:0] addr_q,
    output logic [7:0] data_q,
    output strobes_t   strb_q,
    output strobes_t   rise
);

    logic [7:0] addr_s1, addr_s2, addr_s3;
    logic [7:0] data_s1, data_s2, data_s3;
    strobes_t   strb_s1, strb_s2, strb_s3;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_s1 <= '0;
            addr_s2 <= '0;
            addr_s3 <= '0;
            data_s1 <= '0;
            data_s2 <= '0;
            data_s3 <= '0;
            strb_s1 <= '1;
            strb_s2 <= '1;
            strb_s3 <= '1;
        end else begin
            addr_s1 <= addr;
            addr_s2 <= addr_s1;
            addr_s3 <= addr_s2;
            data_s1 <= data;
            data_s2 <= data_s1;
            data_s3 <= data_s2;
            strb_s1 <= strb;
            strb_s2 <= strb_s1;
            strb_s3 <= strb_s2;
        end
    end

    // Event values are taken from s3: the last sample with the strobe still low.
    assign addr_q = addr_s3;
    assign data_q = data_s3;
    assign strb_q = strb_s3;
    assign rise   = strb_s2 & ~strb_s3;

endmodule

// File: rtl/mapper_bus_ctrl.sv
// MegaMapper Z80 front-end: I/O window decode, control registers, M1 opcode
// capture with prefix tracking, and out-of-window I/O trap with NMI pulse.
module mapper_bus_ctrl
    import mapper_pkg::*;
#(
    parameter logic [7:0]  IO_BASE     = 8'h30,
    parameter int unsigned IO_WIN_BITS = 4,
    parameter int unsigned NUM_CTRL    = 4,
    parameter int unsigned NMI_LEN     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            addr,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic                  data_oe,
    input  logic                  wr_n,
    input  logic                  rd_n,
    input  logic                  iorq_n,
    input  logic                  mreq_n,
    input  logic                  m1_n,
    input  logic                  refresh_n,
    output logic                  iorq_sys_n,
    output logic [8*NUM_CTRL-1:0] ctrl_regs,
    output logic                  trap_nmi_n,
    output logic                  isr_valid
);

    localparam int unsigned W  = IO_WIN_BITS;
    localparam int unsigned CW = $clog2(NMI_LEN + 1);

    strobes_t   strb_raw, strb_q, rise;
    logic [7:0] addr_q, data_q;

    assign strb_raw = '{rd_n: rd_n, wr_n: wr_n, iorq_n: iorq_n, mreq_n: mreq_n,
                        m1_n: m1_n, refresh_n: refresh_n};

    bus_sync u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .addr   (addr),
        .data   (data_in),
        .strb   (strb_raw),
        .addr_q (addr_q),
        .data_q (data_q),
        .strb_q (strb_q),
        .rise   (rise)
    );

    logic unused_strb;
    assign unused_strb = &{rise.iorq_n, rise.mreq_n, rise.m1_n, rise.refresh_n,
                           strb_q.rd_n, strb_q.wr_n};

    logic [7:0]          opcode;
    prefix_e             prefix;
    logic                ovf;
    logic                trap_en;
    logic                trap_pend;
    logic [7:0]          trap_port;
    logic [8*NUM_CTRL-1:0] ctrl_r;
    pfx_state_e          state;
    logic                ix_fd;
    logic [CW-1:0]       nmi_cnt;
    logic                nmi_n;

    // Raw combinational decode
    logic         io_acc, win;
    logic [W-1:0] ofs_raw;

    assign io_acc     = !iorq_n && m1_n;
    assign win        = io_acc && (addr[7:W] == IO_BASE[7:W]);
    assign ofs_raw    = addr[W-1:0];
    assign iorq_sys_n = iorq_n || win || (io_acc && trap_en);
    assign data_oe    = win && !rd_n;

    always_comb begin
        data_out = 8'hFF;
        if (win) begin
            if (ofs_raw == W'(OFS_ISR))
                data_out = opcode;
            else if (ofs_raw == W'(OFS_STAT))
                data_out = {isr_valid, ovf, trap_pend, 2'b00, prefix};
            else if (ofs_raw == W'(OFS_TRAP))
                data_out = {7'd0, trap_en};
            else if (ofs_raw == W'(OFS_TADDR))
                data_out = trap_port;
            for (int unsigned k = 0; k < NUM_CTRL; k++)
                if (ofs_raw == W'(OFS_CTRL + k))
                    data_out = ctrl_r[8*k +: 8];
        end
    end

    // Synchronised bus events
    logic         io_ev, win_q, rd_win, wr_win, trap_ev, fetch_ev, isr_clr;
    logic [W-1:0] ofs_q;

    assign io_ev    = (rise.rd_n || rise.wr_n) && !strb_q.iorq_n && strb_q.m1_n;
    assign win_q    = addr_q[7:W] == IO_BASE[7:W];
    assign ofs_q    = addr_q[W-1:0];
    assign rd_win   = io_ev && win_q && rise.rd_n;
    assign wr_win   = io_ev && win_q && rise.wr_n;
    assign trap_ev  = io_ev && !win_q && trap_en && !trap_pend;
    assign fetch_ev = rise.rd_n && !strb_q.mreq_n && !strb_q.m1_n && strb_q.refresh_n;
    assign isr_clr  = rd_win && (ofs_q == W'(OFS_ISR));

    // Prefix FSM next-state and commit decision
    logic       cm_en;
    prefix_e    cm_pfx;
    logic [7:0] cm_op;
    pfx_state_e st_nxt;
    logic       ix_fd_nxt;

    always_comb begin
        cm_en     = 1'b0;
        cm_pfx    = PFX_NONE;
        cm_op     = data_q;
        st_nxt    = state;
        ix_fd_nxt = ix_fd;
        if (fetch_ev) begin
            unique case (state)
                ST_IDLE: begin
                    if (data_q == 8'hCB)      st_nxt = ST_CB;
                    else if (data_q == 8'hED) st_nxt = ST_ED;
                    else if (data_q == 8'hDD || data_q == 8'hFD) begin
                        st_nxt    = ST_IX;
                        ix_fd_nxt = (data_q == 8'hFD);
                    end else
                        cm_en = 1'b1;
                end
                ST_CB: begin
                    cm_en  = 1'b1;
                    cm_pfx = PFX_CB;
                    st_nxt = ST_IDLE;
                end
                ST_ED: begin
                    cm_en  = 1'b1;
                    cm_pfx = PFX_ED;
                    st_nxt = ST_IDLE;
                end
                ST_IX: begin
                    if (data_q == 8'hCB) begin
                        cm_en  = 1'b1;
                        cm_pfx = PFX_IXCB;
                        cm_op  = 8'hCB;
                        st_nxt = ST_IDLE;
                    end else if (data_q == 8'hDD || data_q == 8'hFD) begin
                        ix_fd_nxt = (data_q == 8'hFD);
                    end else if (data_q == 8'hED) begin
                        st_nxt = ST_ED;
                    end else begin
                        cm_en  = 1'b1;
                        cm_pfx = ix_fd ? PFX_FD : PFX_DD;
                        st_nxt = ST_IDLE;
                    end
                end
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            opcode    <= '0;
            prefix    <= PFX_NONE;
            isr_valid <= 1'b0;
            ovf       <= 1'b0;
            trap_en   <= 1'b0;
            trap_pend <= 1'b0;
            trap_port <= '0;
            ctrl_r    <= '0;
            state     <= ST_IDLE;
            ix_fd     <= 1'b0;
            nmi_cnt   <= '0;
            nmi_n     <= 1'b1;
        end else begin
            if (isr_clr) begin
                isr_valid <= 1'b0;
                ovf       <= 1'b0;
            end
            // A forced same-cycle commit overrides the read-clear, leaving ovf clear.
            if (cm_en) begin
                opcode    <= cm_op;
                prefix    <= cm_pfx;
                isr_valid <= 1'b1;
                ovf       <= isr_valid && !isr_clr;
            end
            state <= st_nxt;
            ix_fd <= ix_fd_nxt;

            if (wr_win && ofs_q == W'(OFS_TRAP))
                trap_en <= data_q[0];
            for (int unsigned k = 0; k < NUM_CTRL; k++)
                if (wr_win && ofs_q == W'(OFS_CTRL + k))
                    ctrl_r[8*k +: 8] <= data_q;

            if (rd_win && ofs_q == W'(OFS_TADDR))
                trap_pend <= 1'b0;
            if (trap_ev) begin
                trap_pend <= 1'b1;
                trap_port <= addr_q;
                nmi_cnt   <= CW'(NMI_LEN);
            end else if (nmi_cnt != '0) begin
                nmi_cnt <= nmi_cnt - 1'b1;
            end
            nmi_n <= (nmi_cnt == '0);
        end
    end

    assign ctrl_regs  = ctrl_r;
    assign trap_nmi_n = nmi_n;

endmodule

// File: tb/tb_mapper_bus_ctrl.sv
// Directed bench for mapper_bus_ctrl: window I/O, opcode capture, trap/NMI, reset.
module tb_mapper_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  addr, data_in, data_out;
    logic        data_oe, wr_n, rd_n, iorq_n, mreq_n, m1_n, refresh_n;
    logic        iorq_sys_n, trap_nmi_n, isr_valid;
    logic [31:0] ctrl_regs;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    mapper_bus_ctrl #(
        .IO_BASE    (8'h30),
        .IO_WIN_BITS(4),
        .NUM_CTRL   (4),
        .NMI_LEN    (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .wr_n      (wr_n),
        .rd_n      (rd_n),
        .iorq_n    (iorq_n),
        .mreq_n    (mreq_n),
        .m1_n      (m1_n),
        .refresh_n (refresh_n),
        .iorq_sys_n(iorq_sys_n),
        .ctrl_regs (ctrl_regs),
        .trap_nmi_n(trap_nmi_n),
        .isr_valid (isr_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d, input string tag);
        @(negedge clk);
        addr = a; data_in = d; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_sys"}, 32'(iorq_sys_n), 32'd1);
        @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic oe,
                           output logic sys);
        @(negedge clk);
        addr = a; iorq_n = 1'b0; rd_n = 1'b0;
        repeat (2) @(negedge clk);
        d = data_out; oe = data_oe; sys = iorq_sys_n;
        @(negedge clk);
        iorq_n = 1'b1; rd_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic read_chk(input logic [7:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        logic oe, sys;
        io_read(a, d, oe, sys);
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic fetch(input logic [7:0] op, input logic is_m1);
        @(negedge clk);
        data_in = op; mreq_n = 1'b0; rd_n = 1'b0; m1_n = !is_m1;
        repeat (3) @(negedge clk);
        rd_n = 1'b1; mreq_n = 1'b1; m1_n = 1'b1;
        if (is_m1) begin
            refresh_n = 1'b0; mreq_n = 1'b0;
            repeat (2) @(negedge clk);
            refresh_n = 1'b1; mreq_n = 1'b1;
        end
        repeat (5) @(negedge clk);
    endtask

    // OUT outside the window, then count NMI-low cycles over a bounded window.
    task automatic trap_out(input logic [7:0] a, output int unsigned low_cnt);
        low_cnt = 0;
        @(negedge clk);
        addr = a; data_in = 8'h00; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        check("trap_out_sys", 32'(iorq_sys_n), 32'd1);
        @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (!trap_nmi_n) low_cnt++;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic oe, sys;
        int unsigned cnt;
        bit seen;

        reset_n = 1'b0; addr = 8'h00; data_in = 8'h00;
        wr_n = 1'b1; rd_n = 1'b1; iorq_n = 1'b1; mreq_n = 1'b1; m1_n = 1'b1; refresh_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_dout", 32'(data_out), 32'hFF);
        check("rst_oe", 32'(data_oe), 32'd0);
        check("rst_ctrl", ctrl_regs, 32'd0);
        check("rst_nmi", 32'(trap_nmi_n), 32'd1);
        check("rst_isrv", 32'(isr_valid), 32'd0);
        check("rst_sys", 32'(iorq_sys_n), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Control register write / readback
        io_write(8'h34, 8'hA5, "wr34");
        check("ctrl0", ctrl_regs, 32'h0000_00A5);
        io_read(8'h34, d, oe, sys);
        check("rd34_data", 32'(d), 32'hA5);
        check("rd34_oe", 32'(oe), 32'd1);
        check("rd34_sys", 32'(sys), 32'd1);
        io_write(8'h37, 8'h3C, "wr37");
        check("ctrl3", ctrl_regs, 32'h3C00_00A5);
        io_write(8'h30, 8'h55, "wr_ro0");
        read_chk(8'h30, 8'h00, "ro0_ignored");
        read_chk(8'h38, 8'hFF, "unmapped8");
        read_chk(8'h32, 8'h00, "trap_ctl_rst");

        // DD CB d op: IXCB commit with opcode CB
        fetch(8'hDD, 1'b1);
        fetch(8'hCB, 1'b1);
        fetch(8'h05, 1'b0);
        fetch(8'h46, 1'b0);
        check("ixcb_isrv", 32'(isr_valid), 32'd1);
        read_chk(8'h31, 8'h85, "ixcb_stat");
        read_chk(8'h30, 8'hCB, "ixcb_op");
        check("ixcb_clr", 32'(isr_valid), 32'd0);
        read_chk(8'h31, 8'h05, "ixcb_stat_clr");

        // ED B0, then 3E unread -> overflow
        fetch(8'hED, 1'b1);
        fetch(8'hB0, 1'b1);
        read_chk(8'h31, 8'h82, "ed_stat");
        fetch(8'h3E, 1'b1);
        read_chk(8'h31, 8'hC0, "ovf_stat");
        read_chk(8'h30, 8'h3E, "ovf_op");
        read_chk(8'h31, 8'h00, "ovf_clr");

        // Trap out-of-window I/O
        io_write(8'h32, 8'h01, "wr_trap");
        read_chk(8'h32, 8'h01, "trap_en");
        trap_out(8'h98, cnt);
        check("nmi_len", cnt, 32'd8);
        read_chk(8'h31, 8'h20, "trap_pend");
        trap_out(8'h99, cnt);
        check("nmi_second", cnt, 32'd0);
        read_chk(8'h33, 8'h98, "trap_port");
        read_chk(8'h31, 8'h00, "pend_clr");

        // Interrupt acknowledge is neither a window access nor a trap
        @(negedge clk);
        addr = 8'h30; m1_n = 1'b0; iorq_n = 1'b0;
        repeat (2) @(negedge clk);
        check("inta_sys", 32'(iorq_sys_n), 32'd0);
        check("inta_oe", 32'(data_oe), 32'd0);
        @(negedge clk);
        m1_n = 1'b1; iorq_n = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (!trap_nmi_n) cnt++;
        end
        check("inta_nmi", cnt, 32'd0);
        read_chk(8'h31, 8'h00, "inta_stat");

        // Reset in the middle of an NMI pulse
        fetch(8'h00, 1'b1);
        check("pre_rst_isrv", 32'(isr_valid), 32'd1);
        @(negedge clk);
        addr = 8'h50; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!trap_nmi_n) seen = 1'b1;
        end
        check("mid_nmi_seen", 32'(seen), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_nmi", 32'(trap_nmi_n), 32'd1);
        check("rst_mid_ctrl", ctrl_regs, 32'd0);
        check("rst_mid_isrv", 32'(isr_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        read_chk(8'h32, 8'h00, "rst_mid_trap");
        read_chk(8'h31, 8'h00, "rst_mid_stat");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mapper_bus_ctrl.md
# mapper_bus_ctrl

Parametrised Z80 bus front-end for the MegaMapper CPLD. It decodes a configurable mapper I/O window and suppresses the system IORQ for it. It holds NUM_CTRL read/write control registers and captures every M1 opcode fetch, with Z80 prefix tracking, into a readable instruction register. It also traps I/O accesses outside the window, latching the port and pulsing an active-low NMI.

## Interface
- IO_BASE, 8'h30, window base; only bits above IO_WIN_BITS are compared
- IO_WIN_BITS, 4, log2 window size (16 ports)
- NUM_CTRL, 4, control registers at offsets 4..4+NUM_CTRL-1; must be ≤ 2^IO_WIN_BITS-4
- NMI_LEN, 8, NMI pulse width in clk cycles (≥1)
- clk  in  1  system clock, ≥4× Z80 clock
- reset_n  in  1  synchronous, active-low reset
- addr  in  8  Z80 A7..A0
- data_in  in  8  Z80 data bus (input side)
- data_out  out  8  read data for the window
- data_oe  out  1  drive enable for data_out
- wr_n, rd_n, iorq_n, mreq_n, m1_n, refresh_n  in  1 each  Z80 strobes
- iorq_sys_n  out  1  IORQ forwarded to the system
- ctrl_regs  out  8*NUM_CTRL  control register contents, reg k at [8k+7:8k]
- trap_nmi_n  out  1  NMI to the Z80, active low
- isr_valid  out  1  instruction register holds an unread capture

## Operation
- Combinational, with no clocked path:
  - io_acc = !iorq_n & m1_n, which excludes interrupt acknowledge.
  - win = io_acc & addr[7:IO_WIN_BITS] == IO_BASE[7:IO_WIN_BITS].
  - iorq_sys_n = iorq_n | win | (io_acc & trap_en).
  - data_oe = win & !rd_n.
  - data_out = register at addr offset (raw addr); unmapped offsets read 8'hFF.
- Sampling: all bus inputs pass through an identical 2-stage pipeline (s1, s2), plus s3 = previous s2. An event is a rising strobe edge: s3 low, s2 high. Event addr/data are the s3 values.
- Window offsets:
  - 0 R: opcode. Read event clears isr_valid and ovf.
  - 1 R: {isr_valid, ovf, trap_pend, 2'b0, prefix[2:0]}.
  - 2 R/W: trap control; bit0 trap_en, other bits read 0.
  - 3 R: trapped port, bit7 of offset 1 unaffected. Read event clears trap_pend.
  - 4+k R/W: ctrl_regs[k]; write event stores the s3 data.
- Fetch = mreq low, m1 low, rd low, refresh_n high. A fetch event is the rd rising edge of a fetch; the byte is the s3 data.
- Prefix FSM, states IDLE, CB, ED, IX (DD/FD seen, remembering which):
  - IDLE: CB→CB; ED→ED; DD/FD→IX; other→commit(NONE).
  - CB: any byte → commit(CB), →IDLE.
  - ED: any byte → commit(ED), →IDLE.
  - IX, CB byte: commit(IXCB, 8'hCB), →IDLE. The displacement and opcode that follow are non-M1 and ignored.
  - IX, DD/FD byte: stay IX, update remembered prefix.
  - IX, ED byte: →ED.
  - IX, other byte: commit(DD or FD), →IDLE.
- Prefix codes: NONE 0, CB 1, ED 2, DD 3, FD 4, IXCB 5.
- commit: loads opcode and prefix, sets isr_valid. If isr_valid was already 1, sets ovf.
- Trap: an io_acc event (rd or wr) outside the window with trap_en=1 and trap_pend=0:
  - latches the port and sets trap_pend;
  - starts the NMI counter: trap_nmi_n low for exactly NMI_LEN cycles.
  - Events while trap_pend=1 are suppressed but not latched.

## Timing
- Reset values:
  - data_out = 8'hFF (idle mux), data_oe 0
  - ctrl_regs 0, trap_en 0, trap_pend 0
  - opcode 0, prefix 0, isr_valid 0, ovf 0
  - FSM IDLE, trap_nmi_n 1, NMI counter 0
- Reset mid-NMI ends the pulse in the same cycle.
- Register update: 3 clk after the raw strobe rises (2 sync + edge detect).
- trap_nmi_n falls on the cycle after trap_pend sets.
- A same-cycle commit and offset-0 read-clear cannot occur (distinct bus cycles). If forced, the commit wins and ovf is cleared.
- Writes to read-only offsets 0, 1, 3 are ignored. Reads of offset 2 and 4+k have no side effect.
- A refresh cycle (refresh_n low) never commits or advances the FSM.

## Structure
- Package mapper_pkg holds:
  - offset constants OFS_ISR, OFS_STAT, OFS_TRAP, OFS_TADDR, OFS_CTRL
  - prefix enum
  - FSM state typedef
- Sub-module bus_sync: the 2-stage pipeline, s3 and rise-edge detects for rd/wr/iorq/mreq/m1/refresh, with aligned addr/data outputs.
- Top holds:
  - decode, register file, prefix FSM
  - trap/NMI counter, output mux

## Test plan
- Reset, then write 8'hA5 to port 8'h34 and read it back → ctrl_regs[7:0]=A5, data_oe high during read, iorq_sys_n stays high throughout.
- Fetch sequence DD, CB, 05, 46 (last two non-M1) → offset 0 = CB, offset 1 = 8'h85. Read offset 0 → isr_valid=0.
- Fetches ED, B0, then 3E without reading → first capture prefix 2/op B0. After 3E: prefix 0, op 3E, ovf=1.
- trap_en=1, OUT to port 8'h98 → iorq_sys_n high. Offset 3 = 98, trap_nmi_n low for exactly 8 clk. A second OUT to 8'h99 before reading offset 3 leaves 98 latched and issues no second pulse.
- Interrupt acknowledge (m1 and iorq low, addr=8'h30) → no window access, no trap, iorq_sys_n low.
- Assert reset_n mid-NMI pulse → trap_nmi_n=1 and all registers 0 on the next edge.
